// File: rtl/cordic_pipe.sv
// rtl/cordic_pipe.sv - pipelined CORDIC (rotation/vectoring); define CORDIC_GAIN_COMP_EN for a 1/K output stage
// Stage 0 pre-rotates into the right half-plane, stages 1..ITER do micro-rotations.
module cordic_pipe #(
   parameter int DATA_W = 16,
   parameter int ITER   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_mode,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   input  logic signed [DATA_W-1:0] z_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W+1:0] x_out,
   output logic signed [DATA_W+1:0] y_out,
   output logic signed [DATA_W-1:0] z_out
);

   localparam int XW = DATA_W + 2;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int NS = ITER + 2;
`else
   localparam int NS = ITER + 1;
`endif

   localparam logic signed [DATA_W-1:0] C_QTR  = {2'b01, {(DATA_W-2){1'b0}}};
   localparam logic signed [DATA_W-1:0] C_HALF = {1'b1, {(DATA_W-1){1'b0}}};

   // Binary-angle arctangent, rounded to nearest LSB.
   function automatic logic signed [DATA_W-1:0] atan_lut(input int i);
      real a;
      a = $atan(1.0 / (2.0 ** i)) * (2.0 ** (DATA_W - 1)) / 3.14159265358979323846;
      return DATA_W'($rtoi(a + 0.5));
   endfunction

   logic [NS-1:0]            r_vld;
   logic [ITER-1:0]          r_mode;
   logic signed [XW-1:0]     r_x [NS];
   logic signed [XW-1:0]     r_y [NS];
   logic signed [DATA_W-1:0] r_z [NS];

   logic signed [XW-1:0]     w_x_nx [NS];
   logic signed [XW-1:0]     w_y_nx [NS];
   logic signed [DATA_W-1:0] w_z_nx [NS];
   logic [NS-1:0]            w_ld;
   logic [NS-1:0]            w_vld_in;
   logic [ITER-1:0]          w_mode_in;

   // A stage stalls only when it and every stage after it are full and the output is blocked.
   generate
      for (genvar k = 0; k < NS; k++) begin : g_ld
         assign w_ld[k] = out_ready | ~(&r_vld[NS-1:k]);
      end
   endgenerate

   assign in_ready  = rst_n & w_ld[0];
   assign w_vld_in  = {r_vld[NS-2:0], in_valid};
   assign w_mode_in = {r_mode[ITER-2:0], in_mode};

   logic signed [XW-1:0] w_xe;
   logic signed [XW-1:0] w_ye;
   logic                 w_rot_q1;
   logic                 w_rot_q2;
   logic                 w_vec_neg;

   assign w_xe      = {{2{x_in[DATA_W-1]}}, x_in};
   assign w_ye      = {{2{y_in[DATA_W-1]}}, y_in};
   assign w_rot_q1  = ~in_mode & (z_in[DATA_W-1 -: 2] == 2'b01);
   assign w_rot_q2  = ~in_mode & (z_in[DATA_W-1 -: 2] == 2'b10);
   assign w_vec_neg = in_mode & x_in[DATA_W-1];

   assign w_x_nx[0] = w_rot_q1 ? -w_ye : w_rot_q2 ? w_ye  : w_vec_neg ? -w_xe : w_xe;
   assign w_y_nx[0] = w_rot_q1 ? w_xe  : w_rot_q2 ? -w_xe : w_vec_neg ? -w_ye : w_ye;
   assign w_z_nx[0] = w_rot_q1 ? z_in - C_QTR :
                      w_rot_q2 ? z_in + C_QTR :
                      w_vec_neg ? z_in + C_HALF : z_in;

   generate
      for (genvar g = 0; g < ITER; g++) begin : g_rot
         localparam logic signed [DATA_W-1:0] C_ATAN = atan_lut(g);
         logic w_d;
         assign w_d = r_mode[g] ? r_y[g][XW-1] : ~r_z[g][DATA_W-1];
         assign w_x_nx[g+1] = w_d ? r_x[g] - (r_y[g] >>> g) : r_x[g] + (r_y[g] >>> g);
         assign w_y_nx[g+1] = w_d ? r_y[g] + (r_x[g] >>> g) : r_y[g] - (r_x[g] >>> g);
         assign w_z_nx[g+1] = w_d ? r_z[g] - C_ATAN : r_z[g] + C_ATAN;
      end
   endgenerate

`ifdef CORDIC_GAIN_COMP_EN
   // 1/K ~ 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
   assign w_x_nx[NS-1] = (r_x[ITER] >>> 1) + (r_x[ITER] >>> 3) - (r_x[ITER] >>> 6)
                       - (r_x[ITER] >>> 9) - (r_x[ITER] >>> 13);
   assign w_y_nx[NS-1] = (r_y[ITER] >>> 1) + (r_y[ITER] >>> 3) - (r_y[ITER] >>> 6)
                       - (r_y[ITER] >>> 9) - (r_y[ITER] >>> 13);
   assign w_z_nx[NS-1] = r_z[ITER];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld  <= '0;
         r_mode <= '0;
         for (int k = 0; k < NS; k++) begin
            r_x[k] <= '0;
            r_y[k] <= '0;
            r_z[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NS; k++) begin
            if (w_ld[k]) begin
               r_vld[k] <= w_vld_in[k];
               r_x[k]   <= w_x_nx[k];
               r_y[k]   <= w_y_nx[k];
               r_z[k]   <= w_z_nx[k];
            end
         end
         for (int k = 0; k < ITER; k++) begin
            if (w_ld[k]) r_mode[k] <= w_mode_in[k];
         end
      end
   end

   assign out_valid = r_vld[NS-1];
   assign x_out     = r_x[NS-1];
   assign y_out     = r_y[NS-1];
   assign z_out     = r_z[NS-1];

endmodule

// File: tb/tb_cordic_pipe.sv
// tb/tb_cordic_pipe.sv - directed self-checking bench for cordic_pipe (DATA_W=16, ITER=16)
module tb_cordic_pipe;
   localparam int DW = 16;
   localparam int IT = 16;
`ifdef CORDIC_GAIN_COMP_EN
   localparam int LAT = IT + 2;
`else
   localparam int LAT = IT + 1;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic in_valid = 1'b0;
   logic in_mode = 1'b0;
   logic out_ready = 1'b0;
   logic signed [DW-1:0] x_in = '0;
   logic signed [DW-1:0] y_in = '0;
   logic signed [DW-1:0] z_in = '0;
   logic in_ready;
   logic out_valid;
   logic signed [DW+1:0] x_out;
   logic signed [DW+1:0] y_out;
   logic signed [DW-1:0] z_out;

   cordic_pipe #(.DATA_W(DW), .ITER(IT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .x_out(x_out), .y_out(y_out), .z_out(z_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic signed [15:0] atan_t [16] = '{16'sd8192, 16'sd4836, 16'sd2555, 16'sd1297,
                                       16'sd651, 16'sd326, 16'sd163, 16'sd81,
                                       16'sd41, 16'sd20, 16'sd10, 16'sd5,
                                       16'sd3, 16'sd1, 16'sd1, 16'sd0};

   task automatic check(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_tol(input string tag, input longint obs, input longint exp, input longint tol);
      longint d;
      d = obs - exp;
      if (d < 0) d = -d;
      total++;
      assert ((d <= tol) === 1'b1) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
      end
   endtask

   function automatic void model(input bit m, input logic signed [15:0] xi, input logic signed [15:0] yi,
                                 input logic signed [15:0] zi, output logic signed [17:0] xo,
                                 output logic signed [17:0] yo, output logic signed [15:0] zo);
      logic signed [17:0] x, y, t, xs, ys;
      logic signed [15:0] z;
      bit d;
      x = xi; y = yi; z = zi;
      if (!m) begin
         if (zi[15:14] == 2'b01) begin t = x; x = -y; y = t; z = z - 16'sd16384; end
         else if (zi[15:14] == 2'b10) begin t = x; x = y; y = -t; z = z + 16'sd16384; end
      end else if (xi < 0) begin
         x = -x; y = -y; z = z + 16'sh8000;
      end
      for (int i = 0; i < IT; i++) begin
         d = m ? y[17] : !z[15];
         xs = x >>> i;
         ys = y >>> i;
         if (d) begin x = x - ys; y = y + xs; z = z - atan_t[i]; end
         else   begin x = x + ys; y = y - xs; z = z + atan_t[i]; end
      end
`ifdef CORDIC_GAIN_COMP_EN
      x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9) - (x >>> 13);
      y = (y >>> 1) + (y >>> 3) - (y >>> 6) - (y >>> 9) - (y >>> 13);
`endif
      xo = x; yo = y; zo = z;
   endfunction

   task automatic run_one(input bit m, input logic signed [15:0] xi, input logic signed [15:0] yi,
                          input logic signed [15:0] zi, output logic signed [17:0] xo,
                          output logic signed [17:0] yo, output logic signed [15:0] zo, output int lat);
      logic signed [17:0] ex, ey;
      logic signed [15:0] ez;
      model(m, xi, yi, zi, ex, ey, ez);
      @(negedge clk);
      in_valid = 1'b1; in_mode = m; x_in = xi; y_in = yi; z_in = zi; out_ready = 1'b1;
      #1;
      check("accept_ready", in_ready, 1);
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (out_valid) begin lat = n; break; end
      end
      xo = x_out; yo = y_out; zo = z_out;
      check("single_x_exact", xo, ex);
      check("single_y_exact", yo, ey);
      check("single_z_exact", zo, ez);
   endtask

   logic signed [17:0] xo, yo, ex, ey, cx, cy;
   logic signed [15:0] zo, ez, dz, cz;
   int lat;
   logic signed [17:0] qx [$];
   logic signed [17:0] qy [$];
   logic signed [15:0] qz [$];
   logic signed [15:0] sx [40];
   logic signed [15:0] sy [40];
   logic signed [15:0] sz [40];
   int sent, got, cyc, nf;

   initial begin
      for (int k = 0; k < 40; k++) begin
         sx[k] = 16'($urandom_range(0, 65535));
         sy[k] = 16'($urandom_range(0, 65535));
         sz[k] = 16'($urandom_range(0, 65535));
      end

      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_x_out", x_out, 0);
      check("rst_z_out", z_out, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_in_ready", in_ready, 1);

`ifndef CORDIC_GAIN_COMP_EN
      run_one(1'b0, 16'sd16384, 16'sd0, 16'sd8192, xo, yo, zo, lat);
      check("rot45_latency", lat, 17);
      check_tol("rot45_x", xo, 19079, 4);
      check_tol("rot45_y", yo, 19079, 4);
      check_tol("rot45_z", zo, 0, 2);

      run_one(1'b0, 16'sd16384, 16'sd0, -16'sd32768, xo, yo, zo, lat);
      check_tol("rotm180_x", xo, -26981, 4);
      check_tol("rotm180_y", yo, 0, 4);

      run_one(1'b1, 16'sd0, 16'sd16384, 16'sd0, xo, yo, zo, lat);
      check_tol("vec90_x", xo, 26981, 4);
      check_tol("vec90_y", yo, 0, 4);
      check_tol("vec90_z", zo, 16384, 2);

      run_one(1'b1, -16'sd16384, 16'sd0, 16'sd0, xo, yo, zo, lat);
      dz = zo + 16'sh8000;
      check_tol("vec180_z_wrapped_err", dz, 0, 2);
`else
      run_one(1'b0, 16'sd16384, 16'sd0, 16'sd16384, xo, yo, zo, lat);
      check("gain_latency", lat, 18);
      check_tol("gain_x", xo, 0, 6);
      check_tol("gain_y", yo, 16384, 6);
`endif

      // 40 back-to-back samples with a 5-cycle output stall
      sent = 0; got = 0; cyc = 0;
      while (got < 40 && cyc < 300) begin
         @(negedge clk);
         out_ready = !(cyc >= 20 && cyc <= 24);
         if (sent < 40) begin
            in_valid = 1'b1; in_mode = sent[0]; x_in = sx[sent]; y_in = sy[sent]; z_in = sz[sent];
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (cyc == 20) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
            cx = x_out; cy = y_out; cz = z_out;
         end else if (cyc > 20 && cyc <= 24) begin
            check("stall_x_hold", x_out, cx);
            check("stall_y_hold", y_out, cy);
            check("stall_z_hold", z_out, cz);
            check("stall_valid_hold", out_valid, 1);
         end
         if (out_valid && out_ready) begin
            if (qx.size() > 0) begin
               check("stream_x", x_out, qx.pop_front());
               check("stream_y", y_out, qy.pop_front());
               check("stream_z", z_out, qz.pop_front());
            end else begin
               check("stream_unexpected_output", 1, 0);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            model(in_mode, x_in, y_in, z_in, ex, ey, ez);
            qx.push_back(ex); qy.push_back(ey); qz.push_back(ez);
            sent++;
         end
         cyc++;
      end
      check("stream_count", got, 40);
      check("stream_sent", sent, 40);

      // 10 samples piled up behind a blocked output, then a short async reset
      nf = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         out_ready = 1'b0;
         in_valid = (nf < 10);
         in_mode = 1'b0; x_in = 16'sd5000 + 16'(n); y_in = 16'sd100; z_in = 16'sd4000;
         #1;
         if (in_valid && in_ready) nf++;
         if (nf == 10 && out_valid) break;
      end
      in_valid = 1'b0;
      check("inflight_count", nf, 10);
      check("pre_rst_out_valid", out_valid, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid, 0);
      check("async_rst_in_ready", in_ready, 0);
      check("async_rst_x_out", x_out, 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("rst_release_in_ready", in_ready, 1);
      check("rst_release_out_valid", out_valid, 0);
      model(1'b0, 16'sd1000, 16'sd2000, 16'sd3000, ex, ey, ez);
      in_valid = 1'b1; in_mode = 1'b0; x_in = 16'sd1000; y_in = 16'sd2000; z_in = 16'sd3000;
      out_ready = 1'b1;
      #1;
      check("rst_new_accept", in_ready, 1);
      lat = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         in_valid = 1'b0;
         #1;
         if (out_valid) begin lat = n; break; end
      end
      check("rst_new_latency", lat, LAT);
      check("rst_new_x", x_out, ex);
      check("rst_new_y", y_out, ey);
      check("rst_new_z", z_out, ez);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
